// File: rtl/alsu_driver.sv
// alsu_driver
//   Pipelined command initiator for the ALSU. Accepts one packed command per
//   cycle, drives the ALSU input registers for exactly one cycle, tracks each
//   command through the fixed ALSU latency, captures alsu_out into a
//   show-ahead response FIFO and returns it with an invalid-operation flag.
//   Credits (stored responses + commands in flight) never exceed DEPTH, so a
//   capture always finds a free FIFO slot.
//
// Parameters
//   DEPTH         response FIFO entries / max outstanding commands (2..16)
//   ALSU_LATENCY  edges from alsu_* update to alsu_out holding the result (>=1)
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   cmd_valid/ready/data  command channel, cmd_data =
//                         {direction, bypass_B, bypass_A, red_op_B, red_op_A,
//                          serial_in, cin, opcode[2:0], B[2:0], A[2:0]}
//   rsp_valid/ready       response channel (FIFO head)
//   rsp_data, rsp_invalid captured ALSU result and invalid flag
//   alsu_*                registered drive to the ALSU inputs
//   alsu_out              ALSU result
//   invalid_count         saturating count of accepted invalid commands
//   busy                  any command in flight or response stored
module alsu_driver #(
   parameter int DEPTH        = 4,
   parameter int ALSU_LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [5:0]  rsp_data,
   output logic        rsp_invalid,
   output logic [2:0]  alsu_A,
   output logic [2:0]  alsu_B,
   output logic [2:0]  alsu_opcode,
   output logic        alsu_cin,
   output logic        alsu_serial_in,
   output logic        alsu_red_op_A,
   output logic        alsu_red_op_B,
   output logic        alsu_bypass_A,
   output logic        alsu_bypass_B,
   output logic        alsu_direction,
   input  logic [5:0]  alsu_out,
   output logic [7:0]  invalid_count,
   output logic        busy
);

   localparam int STAGES = ALSU_LATENCY + 1;
   localparam int CW     = $clog2(DEPTH + STAGES + 1);
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   function automatic logic f_is_invalid(input logic [15:0] d);
      logic [2:0] op;
      logic       red;
      op  = d[8:6];
      red = d[11] | d[12];
      return !d[13] && !d[14] &&
             ((op == 3'b110) || (op == 3'b111) ||
              (red && (op != 3'b000) && (op != 3'b001)));
   endfunction

   function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   logic              w_accept;
   logic              w_cmd_inv;
   logic              w_capture;
   logic              w_cap_inv;
   logic              w_pop;
   logic [CW:0]       w_outstanding;

   logic [15:0]       r_alsu_p0;
   logic [STAGES-1:0] r_vld_p;
   logic [STAGES-1:0] r_inv_p;
   logic [CW-1:0]     r_inflight;
   logic [CW-1:0]     r_rsp_count;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [6:0]        r_mem [DEPTH];
   logic [7:0]        r_inv_cnt;

   assign w_accept      = cmd_valid && cmd_ready;
   assign w_cmd_inv     = f_is_invalid(cmd_data);
   assign w_capture     = r_vld_p[STAGES-1];
   assign w_cap_inv     = r_inv_p[STAGES-1];
   assign w_pop         = rsp_valid && rsp_ready;
   // Registered counts only: a pop frees its credit one cycle later.
   assign w_outstanding = {1'b0, r_rsp_count} + {1'b0, r_inflight};
   assign cmd_ready     = w_outstanding < (CW+1)'(DEPTH);

   // Stage p0: ALSU drive, held for one cycle then returned to all-zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_alsu_p0 <= '0;
      else      r_alsu_p0 <= w_accept ? cmd_data : 16'h0000;
   end

   assign alsu_A         = r_alsu_p0[2:0];
   assign alsu_B         = r_alsu_p0[5:3];
   assign alsu_opcode    = r_alsu_p0[8:6];
   assign alsu_cin       = r_alsu_p0[9];
   assign alsu_serial_in = r_alsu_p0[10];
   assign alsu_red_op_A  = r_alsu_p0[11];
   assign alsu_red_op_B  = r_alsu_p0[12];
   assign alsu_bypass_A  = r_alsu_p0[13];
   assign alsu_bypass_B  = r_alsu_p0[14];
   assign alsu_direction = r_alsu_p0[15];

   // Tracking pipe: last stage lines up with alsu_out holding the result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld_p    <= '0;
         r_inv_p    <= '0;
         r_inflight <= '0;
         r_inv_cnt  <= '0;
      end else begin
         r_vld_p    <= {r_vld_p[STAGES-2:0], w_accept};
         r_inv_p    <= {r_inv_p[STAGES-2:0], w_accept && w_cmd_inv};
         r_inflight <= r_inflight + CW'(w_accept) - CW'(w_capture);
         if (w_accept && w_cmd_inv) r_inv_cnt <= f_sat_inc(r_inv_cnt);
      end
   end

   // Response FIFO control
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_rsp_count <= '0;
      end else begin
         if (w_capture) r_wr_ptr <= f_next_ptr(r_wr_ptr);
         if (w_pop)     r_rd_ptr <= f_next_ptr(r_rd_ptr);
         r_rsp_count <= r_rsp_count + CW'(w_capture) - CW'(w_pop);
      end
   end

   // Storage needs no reset; the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_capture) r_mem[r_wr_ptr] <= {w_cap_inv, alsu_out};
   end

   assign rsp_valid     = (r_rsp_count != '0);
   assign rsp_data      = rsp_valid ? r_mem[r_rd_ptr][5:0] : 6'd0;
   assign rsp_invalid   = rsp_valid ? r_mem[r_rd_ptr][6]   : 1'b0;
   assign invalid_count = r_inv_cnt;
   assign busy          = (r_inflight != '0) || (r_rsp_count != '0);

endmodule

// File: tb/tb_alsu_driver.sv
module tb_alsu_driver;

   localparam int DEPTH = 4;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [5:0]  rsp_data;
   logic        rsp_invalid;
   logic [2:0]  alsu_A, alsu_B, alsu_opcode;
   logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
   logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
   logic [5:0]  alsu_out;
   logic [7:0]  invalid_count;
   logic        busy;

   alsu_driver #(.DEPTH(DEPTH), .ALSU_LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_invalid(rsp_invalid),
      .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
      .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
      .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
      .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
      .alsu_direction(alsu_direction), .alsu_out(alsu_out),
      .invalid_count(invalid_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALSU: input regs, result reg, output reg (latency 3)
   logic [15:0] w_bus;
   logic [15:0] m_in;
   logic [5:0]  m_res;
   assign w_bus = {alsu_direction, alsu_bypass_B, alsu_bypass_A, alsu_red_op_B,
                   alsu_red_op_A, alsu_serial_in, alsu_cin, alsu_opcode,
                   alsu_B, alsu_A};

   function automatic logic [5:0] alsu_fn(input logic [15:0] d, input logic [5:0] prev);
      logic [2:0] a, b, op;
      a = d[2:0]; b = d[5:3]; op = d[8:6];
      if (d[13]) return {3'b0, a};
      if (d[14]) return {3'b0, b};
      if (op[2:1] == 2'b11 || ((d[11] || d[12]) && op[2:1] != 2'b00)) return 6'd0;
      case (op)
         3'd0: return d[11] ? {5'b0, &a} : d[12] ? {5'b0, &b} : {3'b0, a & b};
         3'd1: return d[11] ? {5'b0, ^a} : d[12] ? {5'b0, ^b} : {3'b0, a ^ b};
         3'd2: return 6'(a) + 6'(b) + 6'(d[9]);
         3'd3: return 6'(a) * 6'(b);
         3'd4: return d[15] ? {prev[4:0], d[10]} : {d[10], prev[5:1]};
         default: return d[15] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_in <= '0; m_res <= '0; alsu_out <= '0;
      end else begin
         m_in     <= w_bus;
         m_res    <= alsu_fn(m_in, m_res);
         alsu_out <= m_res;
      end
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Credit/busy tracking and response capture, sampled on the falling edge
   int         outst = 0;
   int         peak  = 0;
   logic [6:0] rq[$];

   always @(negedge clk) begin
      if (!rst) begin
         outst = 0;
      end else begin
         chk("credit_ready", cmd_ready, outst < DEPTH);
         chk("busy_track", busy, outst != 0);
         if (rsp_valid && rsp_ready) rq.push_back({rsp_invalid, rsp_data});
         outst = outst + int'(cmd_valid && cmd_ready) - int'(rsp_valid && rsp_ready);
         if (outst > peak) peak = outst;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "simulation time limit");
   end

   function automatic logic [15:0] mk(input logic dir, input logic bb, input logic ba,
                                      input logic rb, input logic ra, input logic sin,
                                      input logic cin, input logic [2:0] op,
                                      input logic [2:0] b, input logic [2:0] a);
      return {dir, bb, ba, rb, ra, sin, cin, op, b, a};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send1(input logic [15:0] d);
      cmd_valid = 1'b1; cmd_data = d;
      tick();
      cmd_valid = 1'b0; cmd_data = '0;
   endtask

   task automatic get_rsp(input string tag, input logic [6:0] e);
      int n = 0;
      while (rq.size() == 0 && n < 30) begin tick(); n++; end
      chk({tag, "_present"}, rq.size() != 0, 1);
      if (rq.size() != 0) chk(tag, rq.pop_front(), e);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_rsp_invalid"}, rsp_invalid, 0);
      chk({tag, "_inv_count"}, invalid_count, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_alsu_bus"}, w_bus, 0);
   endtask

   logic [15:0] bp_cmd [6];
   logic [15:0] st_cmd [20];
   logic [6:0]  st_exp [20];

   initial begin
      int  idx;
      bit  acc;
      int  n;

      // Reset
      tick(); tick();
      @(negedge clk);
      chk_reset_vals("reset");
      tick(); rst = 1'b1; tick();

      // Add with latency check: 3 + 5 + 1 = 9
      rsp_ready = 1'b0;
      send1(mk(0,0,0,0,0,0,1,3'b010,3'd5,3'd3));
      @(negedge clk);
      chk("add_drive_A", alsu_A, 3);
      chk("add_drive_B", alsu_B, 5);
      chk("add_drive_op", alsu_opcode, 2);
      chk("add_drive_cin", alsu_cin, 1);
      tick();
      @(negedge clk);
      chk("add_drive_idle", w_bus, 0);
      tick(); tick();
      @(negedge clk);
      chk("add_valid_at3", rsp_valid, 0);
      tick();
      @(negedge clk);
      chk("add_valid_at4", rsp_valid, 1);
      chk("add_data", rsp_data, 9);
      chk("add_inv", rsp_invalid, 0);
      tick();
      rsp_ready = 1'b1;
      get_rsp("add_rsp", {1'b0, 6'd9});

      // Multiply 7 * 7 = 49
      send1(mk(0,0,0,0,0,0,0,3'b011,3'd7,3'd7));
      get_rsp("mul", {1'b0, 6'd49});

      // Invalid operations
      send1(mk(0,0,0,0,0,0,0,3'b110,3'd2,3'd2));
      get_rsp("inv_op110", {1'b1, 6'd0});
      @(negedge clk); chk("inv_count1", invalid_count, 1);
      tick();
      send1(mk(0,0,0,0,1,0,0,3'b010,3'd5,3'd3));
      get_rsp("inv_redop", {1'b1, 6'd0});
      @(negedge clk); chk("inv_count2", invalid_count, 2);
      tick();
      send1(mk(0,0,1,0,1,0,0,3'b010,3'd0,3'd6));
      get_rsp("bypass_redop", {1'b0, 6'd6});
      @(negedge clk); chk("inv_count_hold", invalid_count, 2);
      tick();

      // Chaining: bypass 5 then shift left with serial_in=1 -> 11
      cmd_valid = 1'b1;
      cmd_data  = mk(0,0,1,0,0,0,0,3'b000,3'd0,3'd5);
      tick();
      cmd_data  = mk(1,0,0,0,0,1,0,3'b100,3'd0,3'd0);
      tick();
      cmd_valid = 1'b0; cmd_data = '0;
      get_rsp("chain_bypass", {1'b0, 6'd5});
      get_rsp("chain_shift", {1'b0, 6'd11});
      tick(); tick();
      send1(mk(1,0,0,0,0,1,0,3'b100,3'd0,3'd0));
      get_rsp("shift_after_idle", {1'b0, 6'd1});

      // Back-pressure: six adds i+1, only DEPTH accepted
      for (int i = 0; i < 6; i++) bp_cmd[i] = mk(0,0,0,0,0,0,0,3'b010,3'd1,3'(i));
      rsp_ready = 1'b0;
      peak = 0;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         cmd_valid = 1'b1; cmd_data = bp_cmd[idx];
         @(negedge clk); acc = cmd_ready;
         tick();
         if (acc) idx++;
      end
      @(negedge clk);
      chk("bp_accepted", idx, DEPTH);
      chk("bp_ready_low", cmd_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_peak", peak, DEPTH);
      chk("bp_head", rsp_data, 1);
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_in_pop_cycle", cmd_ready, 0);
      tick();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_ready_after_pop", cmd_ready, 1);
      tick();
      idx++;
      cmd_data = bp_cmd[idx];
      @(negedge clk);
      chk("bp_ready_refull", cmd_ready, 0);
      tick();
      rsp_ready = 1'b1;
      n = 0; acc = 1'b0;
      while (!acc && n < 20) begin
         @(negedge clk); acc = cmd_ready;
         tick(); n++;
      end
      cmd_valid = 1'b0; cmd_data = '0;
      chk("bp_sixth_accepted", acc, 1);
      for (int i = 0; i < 6; i++) get_rsp("bp_order", {1'b0, 6'(i + 1)});

      // Streaming with rsp_ready high
      for (int i = 0; i < 20; i++) begin
         logic [2:0] a, b;
         logic       ci;
         a  = 3'($urandom_range(0, 7));
         b  = 3'($urandom_range(0, 7));
         ci = 1'($urandom_range(0, 1));
         if (i % 2 == 0) begin
            st_cmd[i] = mk(0,0,0,0,0,0,ci,3'b010,b,a);
            st_exp[i] = {1'b0, 6'(a) + 6'(b) + 6'(ci)};
         end else begin
            st_cmd[i] = mk(0,0,0,0,0,0,0,3'b011,b,a);
            st_exp[i] = {1'b0, 6'(a) * 6'(b)};
         end
      end
      idx = 0; n = 0;
      while (idx < 20 && n < 200) begin
         cmd_valid = 1'b1; cmd_data = st_cmd[idx];
         @(negedge clk); acc = cmd_ready;
         tick(); n++;
         if (acc) idx++;
      end
      cmd_valid = 1'b0; cmd_data = '0;
      chk("stream_accepted", idx, 20);
      for (int i = 0; i < 20; i++) get_rsp("stream", st_exp[i]);

      // Reset with three commands in flight
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_data = mk(0,0,0,0,0,0,0,3'b010,3'd1,3'd1); tick();
      cmd_data = mk(0,0,0,0,0,0,0,3'b010,3'd2,3'd2); tick();
      cmd_data = mk(0,0,0,0,0,0,0,3'b010,3'd3,3'd3); tick();
      cmd_valid = 1'b0; cmd_data = '0;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrst");
      tick();
      rst = 1'b1; rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      @(negedge clk);
      chk("midrst_no_stale", rq.size(), 0);
      chk("midrst_busy", busy, 0);
      tick();
      send1(mk(0,0,0,0,0,0,1,3'b010,3'd5,3'd3));
      get_rsp("post_reset_add", {1'b0, 6'd9});

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
